// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
//   state_t         : loader FSM states
//   BYTES_PER_WORD  : bytes packed into one instruction word
//   DEFAULT_ADDR_W  : default instruction-memory word-address width
package loader_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned DEFAULT_ADDR_W = 10;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream big-endian into a 32-bit word.
// Ports:
//   clock, reset   : clock and synchronous active-low reset
//   shift_en       : shift byte_in into the low byte of the word
//   byte_in        : stream byte
//   pad            : with shift_en, left-align the partial word (zero-fill low bytes)
//   clear          : return word and byte index to zero
//   word_out       : packed word
//   full           : the next shifted byte completes the word
module byte_packer
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    input  logic        pad,
    input  logic        clear,
    output logic [31:0] word_out,
    output logic        full
);

    logic [31:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] shifted;
    logic [4:0]  pad_shift;

    assign shifted   = {word_q[23:0], byte_in};
    // Bytes still missing after this one is 3 - idx, i.e. ~idx; times 8 bits.
    assign pad_shift = {~idx_q, 3'b000};

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clear) begin
            word_d = '0;
            idx_d  = '0;
        end else if (shift_en) begin
            idx_d  = idx_q + 2'd1;
            word_d = pad ? (shifted << pad_shift) : shifted;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word_out = word_q;
    assign full     = (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_loader.sv
// Program loader: fills the instruction memory from a byte stream and holds
// the core in reset until the whole image is written.
// Ports:
//   clock, reset        : clock and synchronous active-low reset
//   start               : restart loading (honored in DONE or ERROR only)
//   in_valid/in_data/in_last/in_ready : byte stream handshake
//   mem_addr/mem_data/mem_wren        : instruction-memory write port
//   cpu_hold            : keeps the core in reset while high
//   done                : image loaded
//   error               : image overflowed the memory (sticky until start/reset)
//   word_count          : words written in the current load
module instr_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned WORD_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              last_q, last_d;

    logic              accept;
    logic              pack_clear;
    logic              pack_full;
    logic [31:0]       packed_word;

    assign accept = (state_q == LOAD) && in_valid;

    byte_packer u_packer (
        .clock    (clock),
        .reset    (reset),
        .shift_en (accept),
        .byte_in  (in_data),
        .pad      (in_last),
        .clear    (pack_clear),
        .word_out (packed_word),
        .full     (pack_full)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        last_d     = last_q;
        pack_clear = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (accept && (pack_full || in_last)) begin
                    state_d = WRITE;
                    last_d  = in_last;
                end
            end
            WRITE: begin
                count_d    = count_q + 1'b1;
                // The word is in memory after this edge; start the next one empty.
                pack_clear = 1'b1;
                if (last_q) begin
                    state_d = DONE;
                end else if (addr_q == {ADDR_W{1'b1}}) begin
                    state_d = ERROR;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = LOAD;
                end
            end
            DONE, ERROR: begin
                if (start) begin
                    state_d    = LOAD;
                    addr_d     = '0;
                    count_d    = '0;
                    last_d     = 1'b0;
                    pack_clear = 1'b1;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= LOAD;
            addr_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    // Outputs decode from registered state only.
    assign in_ready   = (state_q == LOAD);
    assign mem_wren   = (state_q == WRITE);
    assign mem_addr   = addr_q;
    assign mem_data   = (state_q == WRITE) ? WORD_W'(packed_word) : '0;
    assign cpu_hold   = (state_q != DONE);
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERROR);
    assign word_count = count_q;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BUDGET = 20;

    logic              clock;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              mem_wren;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    int checks = 0;
    int errors = 0;
    int cycles = 0;

    // Expected writes: {addr, data}
    logic [ADDR_W+31:0] exp_q[$];

    instr_loader #(.ADDR_W(ADDR_W), .WORD_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycles++;

    // Scoreboard: every write strobe is popped and compared at the negedge.
    always @(negedge clock) begin
        if (reset === 1'b1 && mem_wren === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h (no write expected)",
                         mem_addr, mem_data);
            end else begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_data} !== e || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL write addr=%0d data=%h in_ready=%b expected addr=%0d data=%h in_ready=0",
                             mem_addr, mem_data, in_ready, e[ADDR_W+31:32], e[31:0]);
                end
            end
        end
    end

    function automatic logic [31:0] gen_word(input int i);
        logic [31:0] v;
        v = (32'(i) + 32'd1) * 32'h9E3779B1;
        return v ^ 32'(i);
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while (in_ready !== 1'b1 && n < BUDGET) begin
            @(posedge clock); #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=%b expected 1 within %0d cycles", in_ready, BUDGET);
        end else begin
            @(posedge clock); #1;
        end
        in_last = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        send_byte(w[31:24], 1'b0);
        send_byte(w[23:16], 1'b0);
        send_byte(w[15:8],  1'b0);
        send_byte(w[7:0],   last);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < BUDGET) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({in_ready, mem_wren, cpu_hold, done, error} !== 5'b10100 || mem_addr !== '0 ||
            mem_data !== '0 || word_count !== '0) begin
            errors++;
            $display("FAIL reset rdy/wren/hold/done/err=%b addr=%0d data=%h wc=%0d expected 10100 0 0 0",
                     {in_ready, mem_wren, cpu_hold, done, error}, mem_addr, mem_data, word_count);
        end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        exp_q.push_back({10'd0, 32'h20400005});
        exp_q.push_back({10'd1, 32'h2480000C});
        send_word(32'h20400005, 1'b0);
        send_word(32'h2480000C, 1'b1);
        in_valid = 1'b0;
        checks++;
        if (mem_wren !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL basic_write_cycle wren=%b done=%b hold=%b expected 1 0 1",
                     mem_wren, done, cpu_hold);
        end
        @(posedge clock); #1;
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 11'd2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_done done=%b hold=%b wc=%0d rdy=%b expected 1 0 2 0",
                     done, cpu_hold, word_count, in_ready);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_pending writes_left=%0d expected 0", exp_q.size());
        end
    endtask

    task automatic test_partial();
        int n;
        pulse_start();
        checks++;
        if (done !== 1'b0 || cpu_hold !== 1'b1 || word_count !== '0 || in_ready !== 1'b1 ||
            mem_addr !== '0) begin
            errors++;
            $display("FAIL restart done=%b hold=%b wc=%0d rdy=%b addr=%0d expected 0 1 0 1 0",
                     done, cpu_hold, word_count, in_ready, mem_addr);
        end
        exp_q.push_back({10'd0, 32'h11223344});
        exp_q.push_back({10'd1, 32'hAABB0000});
        send_word(32'h11223344, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        in_valid = 1'b0;
        wait_done(n);
        checks++;
        if (done !== 1'b1 || word_count !== 11'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL partial_done done=%b wc=%0d left=%0d expected 1 2 0",
                     done, word_count, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        int n;
        pulse_start();
        for (int w = 0; w < 10; w++) exp_q.push_back({10'(w), gen_word(w)});
        c0 = cycles;
        // in_valid stays high across every WRITE cycle.
        for (int w = 0; w < 10; w++) send_word(gen_word(w), (w == 9));
        in_valid = 1'b0;
        wait_done(n);
        checks++;
        if (done !== 1'b1 || cycles - c0 != 50 || word_count !== 11'd10 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL back_to_back done=%b cycles=%0d wc=%0d left=%0d expected 1 50 10 0",
                     done, cycles - c0, word_count, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        int stray_ready;
        int n;
        pulse_start();
        for (int w = 0; w < DEPTH; w++) begin
            exp_q.push_back({10'(w), gen_word(w + 7)});
            send_word(gen_word(w + 7), 1'b0);
        end
        in_valid = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || word_count !== 11'd1024) begin
            errors++;
            $display("FAIL overflow_state err=%b hold=%b done=%b wc=%0d expected 1 1 0 1024",
                     error, cpu_hold, done, word_count);
        end
        // A 1025th word's byte must not be taken; the scoreboard flags any extra write.
        stray_ready = 0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int k = 0; k < 6; k++) begin
            if (in_ready !== 1'b0 || error !== 1'b1) stray_ready++;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (stray_ready != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL overflow_hold bad_cycles=%0d left=%0d expected 0 0", stray_ready, exp_q.size());
        end
        pulse_start();
        checks++;
        if (error !== 1'b0 || in_ready !== 1'b1 || mem_addr !== '0 || word_count !== '0 ||
            cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL overflow_restart err=%b rdy=%b addr=%0d wc=%0d hold=%b expected 0 1 0 0 1",
                     error, in_ready, mem_addr, word_count, cpu_hold);
        end
        exp_q.push_back({10'd0, 32'hCAFEF00D});
        send_word(32'hCAFEF00D, 1'b1);
        in_valid = 1'b0;
        wait_done(n);
        checks++;
        if (done !== 1'b1 || word_count !== 11'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL overflow_reload done=%b wc=%0d left=%0d expected 1 1 0",
                     done, word_count, exp_q.size());
        end
    endtask

    task automatic test_boundary();
        int n;
        pulse_start();
        for (int w = 0; w < DEPTH; w++) begin
            exp_q.push_back({10'(w), gen_word(w + 3000)});
            send_word(gen_word(w + 3000), (w == DEPTH - 1));
        end
        in_valid = 1'b0;
        wait_done(n);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || word_count !== 11'd1024 ||
            exp_q.size() != 0) begin
            errors++;
            $display("FAIL boundary done=%b err=%b hold=%b wc=%0d left=%0d expected 1 0 0 1024 0",
                     done, error, cpu_hold, word_count, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_load();
        int n;
        pulse_start();
        exp_q.push_back({10'd0, gen_word(50)});
        exp_q.push_back({10'd1, gen_word(51)});
        send_word(gen_word(50), 1'b0);
        send_word(gen_word(51), 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({in_ready, mem_wren, cpu_hold, done, error} !== 5'b10100 || mem_addr !== '0 ||
            word_count !== '0) begin
            errors++;
            $display("FAIL mid_reset rdy/wren/hold/done/err=%b addr=%0d wc=%0d expected 10100 0 0",
                     {in_ready, mem_wren, cpu_hold, done, error}, mem_addr, word_count);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        exp_q.push_back({10'd0, 32'h0BADBEEF});
        send_word(32'h0BADBEEF, 1'b1);
        in_valid = 1'b0;
        wait_done(n);
        checks++;
        if (done !== 1'b1 || word_count !== 11'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_reload done=%b wc=%0d left=%0d expected 1 1 0",
                     done, word_count, exp_q.size());
        end
    endtask

    initial begin
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        reset    = 1'b0;
        test_reset();
        test_basic();
        test_partial();
        test_back_to_back();
        test_overflow();
        test_boundary();
        test_reset_mid_load();
        repeat (2) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader that fills the 1024×32 instruction memory of the 16-bit single-cycle core from a byte stream before execution. It is the write side of the instruction-memory interface the core only reads: it packs incoming bytes big-endian into 32-bit instruction words, writes them at consecutive word addresses from 0, and holds the core off (`cpu_hold`) until the image is complete. It sits between the host byte link and the write port of the instruction memory; the core's read port is untouched.

## Interface

Parameters:
- `ADDR_W`, 10, instruction-memory word-address width; depth is 2^ADDR_W.
- `WORD_W`, 32, instruction width; always 4 bytes.

Ports:
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low.
- `start`  in  1  single-cycle pulse that restarts loading; honored only in DONE or ERROR.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  stream byte; the first byte of a word is bits 31:24.
- `in_last`  in  1  qualifies the final byte of the image.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_addr`  out  ADDR_W  instruction-memory write address.
- `mem_data`  out  WORD_W  instruction-memory write data.
- `mem_wren`  out  1  write strobe, one cycle per word.
- `cpu_hold`  out  1  keeps the core's `reset` asserted while high.
- `done`  out  1  image loaded.
- `error`  out  1  image overflowed the memory.
- `word_count`  out  ADDR_W+1  number of words written in the current load.

## Operation

- States:
  - LOAD: collecting bytes.
  - WRITE: one-cycle memory write.
  - DONE: image complete.
  - ERROR: overflow.
- Reset:
  - state=LOAD, byte index 0, address 0, shift register 0, `word_count`=0.
  - `cpu_hold`=1, `in_ready`=1, `mem_wren`=0, `done`=0, `error`=0, `mem_addr`=0, `mem_data`=0.
- LOAD:
  - `in_ready`=1.
  - On `in_valid & in_ready`: the byte is shifted into the word, index+1.
  - After the 4th byte, or any byte with `in_last`, go to WRITE.
  - On an early `in_last`, the unfilled low bytes are zero-padded, so partial words are left-aligned.
- WRITE:
  - `in_ready`=0, `mem_wren`=1, `mem_addr`=current address, `mem_data`=packed word.
  - `word_count` increments at the end of the cycle.
  - Next state:
    - If the word carried `in_last`: DONE.
    - Else if the address is 2^ADDR_W−1: ERROR.
    - Else: address+1, index 0, LOAD.
- DONE:
  - `cpu_hold`=0, `done`=1, `in_ready`=0.
  - `start` returns to LOAD with address 0, `word_count`=0, `done`=0, `cpu_hold`=1.
- ERROR:
  - `error`=1 (sticky), `cpu_hold`=1, `in_ready`=0.
  - Further bytes are ignored; only `start` or `reset` leaves this state.
  - `start` behaves as in DONE and also clears `error`.
- `start` in LOAD or WRITE is ignored.
- `in_valid` with `in_ready`=0 is not consumed; the source holds the byte.
- An `in_last` byte that fills the last address goes to DONE, not ERROR.

## Timing

- `in_ready`, `mem_wren`, `cpu_hold`, `done` and `error` decode from registered state only; there is no combinational path from inputs.
- A 4th byte accepted at edge N gives `mem_wren`=1 during cycle N→N+1, and the memory captures the word at edge N+1.
- Maximum throughput is 5 cycles per word: 4 accepts plus 1 write.
- `done` rises the cycle after the final WRITE.
- `cpu_hold` falls the same cycle `done` rises, so the core's first fetch of address 0 sees the complete image.
- Reset mid-load: all outputs return to reset values on the next edge. Partially written memory is not cleared; a reload overwrites it.

## Structure

- Shared package `loader_pkg`:
  - state enum {LOAD, WRITE, DONE, ERROR};
  - `BYTES_PER_WORD`=4;
  - default `ADDR_W`=10.
- Sub-module `byte_packer`:
  - 32-bit left shift register with a 2-bit byte index;
  - inputs: `shift_en`, `byte_in`, `pad` (zero-fill to a word boundary), `clear`;
  - outputs: `word_out`, `full`.
- The FSM, address counter and `word_count` live in `instr_loader`.

## Test plan

- Basic load: 8 bytes 0x20,0x40,0x00,0x05, 0x24,0x80,0x00,0x0C, with `in_last` on byte 8 → writes addr0=0x20400005 and addr1=0x2480000C; `word_count`=2; `done`=1 and `cpu_hold`=0 one cycle after the 2nd write.
- Partial word: 6 bytes, last=0xAA,0xBB → addr1=0xAABB0000, `done`=1.
- Backpressure: `in_valid` held high throughout → `in_ready`=0 during every WRITE, no byte lost or duplicated, a byte at in_data during WRITE is consumed on the following LOAD cycle; 40 bytes complete in 50 cycles.
- Overflow: 1025 words without `in_last` → 1024 writes, `error`=1, `cpu_hold`=1, no 1025th `mem_wren`; `start` → LOAD at address 0 with `error`=0.
- Boundary: exactly 1024 words, `in_last` on the final byte → DONE, `error`=0, `word_count`=1024.
- Reset mid-load: `reset`=0 after 2 bytes of word 3 → next cycle state LOAD, address 0, `cpu_hold`=1; a fresh 4-byte image writes addr0.
